// File: rtl/uart_reg_writer.sv
// UART 8N1 receiver plus two-byte command parser (header, data) that drives
// the register file write port from the serial line.
module uart_reg_writer #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       write_enable,
    output logic [2:0] write_address,
    output logic [7:0] write_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic {
        CMD_WAIT,
        DATA_WAIT
    } cmd_state_t;

    logic             rx_meta;
    logic             rx_s;
    rx_state_t        rx_state;
    rx_state_t        rx_state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_cnt_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             byte_done_c;
    logic             byte_err_c;

    cmd_state_t       cmd_state;
    cmd_state_t       cmd_state_next;
    logic [2:0]       addr;
    logic [2:0]       addr_next;
    logic             write_enable_next;
    logic [2:0]       write_address_next;
    logic [7:0]       write_data_next;

    // Receiver: samples mid-bit, counting from the first low cycle of the start bit
    always_comb begin
        rx_state_next = rx_state;
        cnt_next      = cnt + CNT_W'(1);
        bit_cnt_next  = bit_cnt;
        shift_next    = shift;
        byte_done_c   = 1'b0;
        byte_err_c    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    rx_state_next = RX_START;
                    bit_cnt_next  = '0;
                end
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next      = '0;
                    rx_state_next = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        byte_done_c   = 1'b1;
                        rx_state_next = RX_IDLE;
                    end else begin
                        byte_err_c    = 1'b1;
                        rx_state_next = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                // A line held low must go high before another frame can start
                cnt_next = '0;
                if (rx_s) begin
                    rx_state_next = RX_IDLE;
                end
            end
            default: begin
                cnt_next      = '0;
                rx_state_next = RX_IDLE;
            end
        endcase
    end

    // Parser: acts on the completed byte in the stop-sample cycle so the write
    // strobe lines up with rx_valid
    always_comb begin
        cmd_state_next     = cmd_state;
        addr_next          = addr;
        write_enable_next  = 1'b0;
        write_address_next = write_address;
        write_data_next    = write_data;
        if (byte_err_c) begin
            cmd_state_next = CMD_WAIT;
        end else if (byte_done_c) begin
            case (cmd_state)
                CMD_WAIT: begin
                    if (shift[7]) begin
                        addr_next      = shift[2:0];
                        cmd_state_next = DATA_WAIT;
                    end
                end
                DATA_WAIT: begin
                    write_enable_next  = 1'b1;
                    write_address_next = addr;
                    write_data_next    = shift;
                    cmd_state_next     = CMD_WAIT;
                end
                default: cmd_state_next = CMD_WAIT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            rx_state      <= RX_IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            cmd_state     <= CMD_WAIT;
            addr          <= '0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            rx_byte       <= '0;
            rx_valid      <= 1'b0;
            frame_error   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            rx_meta       <= rx;
            rx_s          <= rx_meta;
            rx_state      <= rx_state_next;
            cnt           <= cnt_next;
            bit_cnt       <= bit_cnt_next;
            shift         <= shift_next;
            cmd_state     <= cmd_state_next;
            addr          <= addr_next;
            write_enable  <= write_enable_next;
            write_address <= write_address_next;
            write_data    <= write_data_next;
            if (byte_done_c) begin
                rx_byte <= shift;
            end
            rx_valid      <= byte_done_c;
            frame_error   <= byte_err_c;
            busy          <= (rx_state_next != RX_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_reg_writer.sv
// Randomized bench for uart_reg_writer: frames are driven bit by bit and the
// observed events are compared with a byte-level reference model.
module tb_uart_reg_writer;

    localparam int unsigned N   = 16;
    // Driving edge -> two synchronizer flops -> half bit + nine bits -> pulse
    localparam int unsigned LAT = 3 + N / 2 + 9 * N;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic       write_enable;
    logic [2:0] write_address;
    logic [7:0] write_data;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_error;
    logic       busy;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    // Reference model state: pending header and last good byte
    bit         pend      = 1'b0;
    logic [2:0] paddr     = '0;
    logic [7:0] last_good = '0;

    // Events packed as {cycle[19:0], payload[11:0]}
    logic [31:0] got_v[$];
    logic [31:0] exp_v[$];
    logic [31:0] got_e[$];
    logic [31:0] exp_e[$];
    logic [31:0] got_w[$];
    logic [31:0] exp_w[$];

    uart_reg_writer #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .write_enable (write_enable),
        .write_address(write_address),
        .write_data   (write_data),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset) begin
            if (rx_valid)     got_v.push_back({cyc[19:0], 4'h0, rx_byte});
            if (frame_error)  got_e.push_back({cyc[19:0], 12'h0});
            if (write_enable) got_w.push_back({cyc[19:0], 1'b0, write_address, write_data});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    // Called at a negedge; model predicts the frame's effect before driving it
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold);
        int unsigned c;
        c = cyc + LAT;
        if (stop_ok) begin
            exp_v.push_back({c[19:0], 4'h0, b});
            last_good = b;
            if (pend) begin
                exp_w.push_back({c[19:0], 1'b0, paddr, b});
                pend = 1'b0;
            end else if (b[7]) begin
                pend  = 1'b1;
                paddr = b[2:0];
            end
        end else begin
            exp_e.push_back({c[19:0], 12'h0});
            pend = 1'b0;
        end
        rx = 1'b0;
        repeat (N) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (N) @(negedge clock);
        end
        rx = stop_ok;
        repeat (N) @(negedge clock);
        if (!stop_ok) begin
            repeat (hold) @(negedge clock);
            chk("busy_break", 32'(busy), 32'd1);
            chk("rx_byte_hold", 32'(rx_byte), 32'(last_good));
            rx = 1'b1;
            repeat (4) @(negedge clock);
            chk("busy_idle", 32'(busy), 32'd0);
        end
    endtask

    task automatic check_events(input string tag);
        idle(4);
        chk({tag, "_n_valid"}, 32'(got_v.size()), 32'(exp_v.size()));
        chk({tag, "_n_ferr"},  32'(got_e.size()), 32'(exp_e.size()));
        chk({tag, "_n_write"}, 32'(got_w.size()), 32'(exp_w.size()));
        for (int i = 0; i < got_v.size() && i < exp_v.size(); i++)
            chk({tag, "_valid"}, got_v[i], exp_v[i]);
        for (int i = 0; i < got_e.size() && i < exp_e.size(); i++)
            chk({tag, "_ferr"}, got_e[i], exp_e[i]);
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
            chk({tag, "_write"}, got_w[i], exp_w[i]);
        got_v.delete(); exp_v.delete();
        got_e.delete(); exp_e.delete();
        got_w.delete(); exp_w.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"},    32'(write_enable),  32'd0);
        chk({tag, "_wa"},    32'(write_address), 32'd0);
        chk({tag, "_wd"},    32'(write_data),    32'd0);
        chk({tag, "_byte"},  32'(rx_byte),       32'd0);
        chk({tag, "_valid"}, 32'(rx_valid),      32'd0);
        chk({tag, "_ferr"},  32'(frame_error),   32'd0);
        chk({tag, "_busy"},  32'(busy),          32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int unsigned c0;
        logic [7:0]  rb;
        bit          ok;

        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_outputs("por");
        reset = 1'b1;
        idle(4);

        // Header then data
        send_frame(8'h83, 1'b1, 0);
        send_frame(8'h5A, 1'b1, 0);
        check_events("hdr_data");

        // Non-header discarded; data byte with bit7 set still counts as data
        send_frame(8'h23, 1'b1, 0);
        send_frame(8'h81, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        check_events("data_bit7");

        // Framing error drops the pending header
        send_frame(8'h85, 1'b1, 0);
        send_frame(8'h3C, 1'b0, 2 * N);
        send_frame(8'h11, 1'b1, 0);
        check_events("ferr");

        // Short low glitch on the idle line
        idle(8);
        c0 = cyc;
        rx = 1'b0;
        repeat (2) @(negedge clock);
        chk("glitch_busy_pre", 32'(busy), 32'd0);
        @(negedge clock);
        rx = 1'b1;
        chk("glitch_busy_rise", 32'(busy), 32'd1);
        repeat (7) @(negedge clock);
        chk("glitch_cycle", cyc, c0 + 10);
        chk("glitch_busy_hold", 32'(busy), 32'd1);
        @(negedge clock);
        chk("glitch_busy_fall", 32'(busy), 32'd0);
        check_events("glitch");

        // Reset in the middle of the data byte following a header
        send_frame(8'h87, 1'b1, 0);
        rb = 8'hC6;
        rx = 1'b0;
        repeat (N) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rx = rb[i];
            repeat (N) @(negedge clock);
        end
        reset = 1'b0;
        rx    = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clock);
        check_reset_outputs("midrst_hold");
        pend      = 1'b0;
        last_good = '0;
        reset     = 1'b1;
        idle(2 * N);
        send_frame(8'h42, 1'b1, 0);
        check_events("after_rst");

        // Two commands with no idle between frames
        send_frame(8'h80, 1'b1, 0);
        send_frame(8'h01, 1'b1, 0);
        send_frame(8'h87, 1'b1, 0);
        send_frame(8'hF0, 1'b1, 0);
        check_events("b2b");

        // Random byte stream with occasional framing errors and gaps
        for (int k = 0; k < 40; k++) begin
            rb = 8'($urandom);
            ok = ($urandom_range(9, 0) != 0);
            send_frame(rb, ok, int'($urandom_range(20, 0)));
            if ($urandom_range(1, 0) != 0) idle(int'($urandom_range(30, 1)));
        end
        check_events("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_reg_writer.md
# uart_reg_writer

UART 8N1 receiver and command parser that acts as a remote writer for the 8×8-bit register file. It samples the board serial input, assembles bytes, decodes two-byte write commands (header + data), and drives the register file write port (write_enable / write_address / write_data) in place of the switch/KEY writer. It sits at the top level between UART_RXD and the register file write port, clocked by CLOCK_50.

## Interface
- CLK_FREQ, 50000000, input clock frequency in Hz
- BAUD, 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 434 at defaults; must be ≥ 4)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- rx  in  1  serial input (UART_RXD), idle high, asynchronous to clock
- write_enable  out  1  one-cycle write strobe to the register file
- write_address  out  3  register index for the write
- write_data  out  8  data for the write
- rx_byte  out  8  last correctly framed byte
- rx_valid  out  1  one-cycle pulse, rx_byte updated
- frame_error  out  1  one-cycle pulse, stop bit sampled low
- busy  out  1  high while a frame is being received (any receiver state except IDLE)

## Operation
- rx passes through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value rx_s.
- Receiver FSM: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on rx_s == 0 → START, bit counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, sample rx_s; 0 → DATA, 1 → IDLE (glitch, no pulse).
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into a shift register; after bit 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles sample rx_s. If 1: rx_byte ← shift register, rx_valid pulse, → IDLE. If 0: frame_error pulse, byte discarded, → BREAK.
  - BREAK: wait for rx_s == 1, then → IDLE (a held-low line never re-triggers a frame).
- Command parser (states CMD_WAIT, DATA_WAIT), advanced only by rx_valid / frame_error:
  - CMD_WAIT: byte with bit7 = 1 is a header; latch address = byte[2:0] (bits 6:3 ignored) and go to DATA_WAIT. A byte with bit7 = 0 is discarded and the parser stays in CMD_WAIT.
  - DATA_WAIT: any byte, including one with bit7 = 1, is data. write_data ← byte, write_address ← latched address, write_enable pulse, → CMD_WAIT.
  - frame_error in either state → CMD_WAIT, pending header dropped, no write.
- write_address / write_data hold their values between writes.

## Timing
- Reset values: write_enable 0, write_address 0, write_data 0, rx_byte 0, rx_valid 0, frame_error 0, busy 0, receiver IDLE, parser CMD_WAIT, synchronizer 1.
- Let N = CLKS_PER_BIT and let t0 be the first cycle rx_s == 0 in IDLE. Start sample at t0 + N/2; data bit k sampled at t0 + N/2 + (k+1)·N; stop sample at t0 + N/2 + 9N.
- rx_valid / frame_error are asserted in the cycle after the stop sample, for exactly 1 cycle.
- write_enable is asserted in the same cycle as rx_valid of the data byte, for 1 cycle, with write_address / write_data already valid in that cycle.
- busy rises the cycle after t0 and falls when the receiver returns to IDLE; it stays high during BREAK.
- Back-to-back frames: a start bit immediately after the stop bit is accepted (IDLE lasts ≥ 1 cycle).
- Async reset mid-frame aborts the frame and any pending header; no strobe is produced.

## Test plan
- CLK_FREQ=16, BAUD=1 (N=16). Send 0x83 then 0x5A → rx_valid twice; write_enable exactly once, with write_address=3 and write_data=0x5A, in the same cycle as the second rx_valid.
- Send 0x23 (bit7=0) then 0x81, 0xFF → first byte ignored; single write with address 1, data 0xFF; data byte 0xFF with bit7=1 is accepted as data.
- Send 0x85, then a frame with stop bit 0, then 0x11 → frame_error pulse; no write; 0x11 is discarded in CMD_WAIT; busy stays high until rx returns high.
- 3-cycle low glitch on idle rx → no rx_valid, no frame_error; busy returns low by cycle N/2+2.
- Assert reset after 4 data bits of the data byte following header 0x87, release, send 0x42 → no write; parser in CMD_WAIT, so 0x42 is ignored; all outputs read their reset values during reset.
- Two commands back-to-back with no idle gap (0x80,0x01,0x87,0xF0) → writes (0,0x01) then (7,0xF0), each strobe 1 cycle.
